// File: rtl/enemy_spawn_sched.sv
// Enemy spawn scheduler: frame-timed weighted class pick with free-slot fallback.
// Define SPAWN_LEVEL_EN to enable the difficulty ramp (level, period, enemy3 gate).
module enemy_spawn_sched #(
   parameter int PERIOD_INIT  = 60,
   parameter int PERIOD_MIN   = 15,
   parameter int PERIOD_STEP  = 5,
   parameter int LEVEL_FRAMES = 600,
   parameter int LEVEL_MAX    = 15,
   parameter int E3_LEVEL     = 2,
   parameter int THR0         = 160,
   parameter int THR1         = 224
) (
   input  logic       clk_vga,
   input  logic       rst,
   input  logic       en_i,
   input  logic       v_sync_i,
   input  logic [7:0] rand_i,
   input  logic [2:0] free_i,
   output logic [2:0] spawn_o,
   output logic [3:0] level_o,
   output logic [7:0] period_o
);

   typedef enum logic [2:0] {
      IDLE, WAIT, PICK, CHECK, HOLD, FIRE
   } state_t;

   state_t     state, state_n;
   logic       vs_q, tick;
   logic [2:0] free_q, elig;
   logic [7:0] fcnt, fcnt_n;
   logic [1:0] choice, choice_n;
   logic [1:0] sel, sel_n;
   logic [1:0] pick, hit;
   logic       hit_v, lvl_ok;

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         vs_q   <= 1'b0;
         tick   <= 1'b0;
         free_q <= '0;
      end else begin
         vs_q   <= v_sync_i;
         tick   <= v_sync_i & ~vs_q;
         free_q <= free_i;
      end
   end

`ifdef SPAWN_LEVEL_EN
   localparam int LW = $clog2(LEVEL_FRAMES);

   logic [LW-1:0]     lcnt;
   logic [3:0]        level_n;
   logic signed [8:0] per_s;
   logic [7:0]        per_n;
   logic              lcount, lwrap;

   assign lcount = tick && (state != IDLE);
   assign lwrap  = lcount && (lcnt == LW'(LEVEL_FRAMES - 1));
   assign lvl_ok = (level_o >= 4'(E3_LEVEL));

   // period is derived from the next level so both update together
   always_comb begin
      level_n = level_o;
      if (lwrap && level_o != 4'(LEVEL_MAX))
         level_n = level_o + 4'd1;
      per_s = $signed(9'(PERIOD_INIT) - 9'(level_n) * 9'(PERIOD_STEP));
      per_n = per_s[7:0];
      if (per_s < $signed(9'(PERIOD_MIN)))
         per_n = 8'(PERIOD_MIN);
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         lcnt     <= '0;
         level_o  <= '0;
         period_o <= 8'(PERIOD_INIT);
      end else if (lcount) begin
         lcnt     <= lwrap ? '0 : lcnt + LW'(1);
         level_o  <= level_n;
         period_o <= per_n;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{32'(PERIOD_MIN), 32'(PERIOD_STEP),
                         32'(LEVEL_FRAMES), 32'(LEVEL_MAX),
                         32'(E3_LEVEL)};
   assign lvl_ok     = 1'b1;
   assign level_o    = '0;
   assign period_o   = 8'(PERIOD_INIT);
`endif

   always_comb begin
      pick = 2'd2;
      if (rand_i < 8'(THR0))
         pick = 2'd0;
      else if (rand_i < 8'(THR1))
         pick = 2'd1;
      if (pick == 2'd2 && !lvl_ok)
         pick = 2'd1;
   end

   // search: choice, then lower indices downward, then higher upward
   always_comb begin
      elig  = free_q & {lvl_ok, 2'b11};
      hit   = 2'd0;
      hit_v = 1'b1;
      unique case (choice)
         2'd0: begin
            if (elig[0])      hit = 2'd0;
            else if (elig[1]) hit = 2'd1;
            else if (elig[2]) hit = 2'd2;
            else              hit_v = 1'b0;
         end
         2'd1: begin
            if (elig[1])      hit = 2'd1;
            else if (elig[0]) hit = 2'd0;
            else if (elig[2]) hit = 2'd2;
            else              hit_v = 1'b0;
         end
         2'd2: begin
            if (elig[2])      hit = 2'd2;
            else if (elig[1]) hit = 2'd1;
            else if (elig[0]) hit = 2'd0;
            else              hit_v = 1'b0;
         end
         default: hit_v = 1'b0;
      endcase
   end

   always_comb begin
      state_n  = state;
      fcnt_n   = fcnt;
      choice_n = choice;
      sel_n    = sel;
      spawn_o  = '0;
      unique case (state)
         IDLE: begin
            fcnt_n = '0;
            if (en_i)
               state_n = WAIT;
         end
         WAIT: begin
            if (tick) begin
               if (fcnt >= period_o - 8'd1)
                  state_n = PICK;
               else
                  fcnt_n = fcnt + 8'd1;
            end
         end
         PICK: begin
            choice_n = pick;
            state_n  = CHECK;
         end
         CHECK, HOLD: begin
            if (hit_v) begin
               sel_n   = hit;
               state_n = FIRE;
            end else begin
               state_n = HOLD;
            end
         end
         FIRE: begin
            spawn_o = 3'b001 << sel;
            fcnt_n  = '0;
            state_n = WAIT;
         end
         default: state_n = IDLE;
      endcase
      if (!en_i) begin
         state_n = IDLE;
         fcnt_n  = '0;
      end
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         fcnt   <= '0;
         choice <= '0;
         sel    <= '0;
      end else begin
         state  <= state_n;
         fcnt   <= fcnt_n;
         choice <= choice_n;
         sel    <= sel_n;
      end
   end

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// Self-checking bench for enemy_spawn_sched: frame-level reference model
// compared every cycle, plus directed literal checks.
module tb_enemy_spawn_sched;

   logic       clk_vga = 1'b0;
   logic       rst;
   logic       en_i;
   logic       v_sync_i;
   logic [7:0] rand_i;
   logic [2:0] free_i;
   logic [2:0] spawn_o;
   logic [3:0] level_o;
   logic [7:0] period_o;

   int         n_chk;
   int         n_fail;
   int         tot;
   logic [2:0] seen;

`ifdef SPAWN_LEVEL_EN
   localparam int EXP240 = 2;
`else
   localparam int EXP240 = 4;
`endif

   always #5 clk_vga = ~clk_vga;

   enemy_spawn_sched dut (
      .clk_vga  (clk_vga),
      .rst      (rst),
      .en_i     (en_i),
      .v_sync_i (v_sync_i),
      .rand_i   (rand_i),
      .free_i   (free_i),
      .spawn_o  (spawn_o),
      .level_o  (level_o),
      .period_o (period_o)
   );

   typedef struct packed {
      int         run_ticks;
      int         frames;
      int         phase;
      int         choice;
      logic       running;
      logic       vs_prev;
      logic       rise;
      logic [2:0] free_prev;
      logic [2:0] spawn;
   } mdl_t;

   mdl_t m;

   function automatic int lvl(int t);
`ifdef SPAWN_LEVEL_EN
      return (t / 600 > 15) ? 15 : t / 600;
`else
      return 0;
`endif
   endfunction

   function automatic int per(int l);
      int p = 60 - 5 * l;
      return (p < 15) ? 15 : p;
   endfunction

   function automatic bit elig(int k, int l);
`ifdef SPAWN_LEVEL_EN
      return (k != 2) || (l >= 2);
`else
      return 1'b1;
`endif
   endfunction

   function automatic int find(int c, logic [2:0] f, int l);
      for (int k = c; k >= 0; k--)
         if (f[k] && elig(k, l)) return k;
      for (int k = c + 1; k <= 2; k++)
         if (f[k] && elig(k, l)) return k;
      return -1;
   endfunction

   function automatic mdl_t mstep(mdl_t c, logic vs, logic en,
                                  logic [7:0] r, logic [2:0] fr);
      mdl_t n = c;
      int   l = lvl(c.run_ticks);
      int   s;
      n.rise      = vs & ~c.vs_prev;
      n.vs_prev   = vs;
      n.free_prev = fr;
      n.spawn     = '0;
      if (c.running && c.rise)
         n.run_ticks = c.run_ticks + 1;
      if (!en) begin
         n.running = 1'b0;
         n.frames  = 0;
         n.phase   = 0;
      end else if (!c.running) begin
         n.running = 1'b1;
         n.frames  = 0;
         n.phase   = 0;
      end else if (c.spawn != 0) begin
         n.frames = 0;
         n.phase  = 0;
      end else if (c.phase == 0) begin
         if (c.rise) begin
            if (c.frames >= per(l) - 1) n.phase = 1;
            else n.frames = c.frames + 1;
         end
      end else if (c.phase == 1) begin
         n.choice = (r < 160) ? 0 : (r < 224) ? 1 : (elig(2, l) ? 2 : 1);
         n.phase  = 2;
      end else begin
         s = find(c.choice, c.free_prev, l);
         if (s >= 0) begin
            n.spawn  = 3'(1 << s);
            n.phase  = 0;
            n.frames = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk_vga or posedge rst) begin
      if (rst) m <= '0;
      else     m <= mstep(m, v_sync_i, en_i, rand_i, free_i);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk_vga);
      if (!rst) begin
         chk("model_spawn", int'(spawn_o), int'(m.spawn));
         chk("model_level", int'(level_o), lvl(m.run_ticks));
         chk("model_period", int'(period_o), per(lvl(m.run_ticks)));
         seen = seen | spawn_o;
      end
   endtask

   task automatic frame();
      if (en_i) tot++;
      v_sync_i = 1'b1;
      step();
      v_sync_i = 1'b0;
      step();
      step();
      step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic run_to(input int target);
      while (tot < target) frame();
   endtask

   initial begin
      rst = 1'b1; en_i = 1'b0; v_sync_i = 1'b0;
      rand_i = '0; free_i = '0;
      n_chk = 0; n_fail = 0; tot = 0; seen = '0;
      repeat (3) @(negedge clk_vga);
      chk("rst_spawn", int'(spawn_o), 0);
      chk("rst_level", int'(level_o), 0);
      chk("rst_period", int'(period_o), 60);

      rst = 1'b0; en_i = 1'b1; free_i = 3'b111;
      step();
      seen = '0; run(59); chk("no_early_spawn", int'(seen), 0);
      run(1); chk("first_spawn", int'(spawn_o), 1);
      seen = '0; run(59); chk("period_gap", int'(seen), 0);
      run(1); chk("second_spawn", int'(spawn_o), 1);

      rand_i = 8'd240; run(60); chk("rand240_lvl0", int'(spawn_o), EXP240);

      rand_i = 8'd200; free_i = 3'b001;
      run(60); chk("fallback_lower", int'(spawn_o), 1);
      free_i = 3'b000;
      run(60); chk("hold_enter", int'(spawn_o), 0);
      step(); chk("hold_stay", int'(spawn_o), 0);
      free_i = 3'b010;
      step(); chk("hold_check", int'(spawn_o), 0);
      step(); chk("hold_fire", int'(spawn_o), 2);

      rand_i = 8'd0; free_i = 3'b111;
      run(30); en_i = 1'b0; step();
      seen = '0; run(100);
      chk("pause_quiet", int'(seen), 0);
      chk("pause_level", int'(level_o), 0);
      en_i = 1'b1;
      seen = '0; run(59); chk("resume_early", int'(seen), 0);
      run(1); chk("resume_spawn", int'(spawn_o), 1);

`ifdef SPAWN_LEVEL_EN
      run_to(600);
      chk("level1", int'(level_o), 1);
      chk("period1", int'(period_o), 55);
      run_to(1200);
      chk("level2", int'(level_o), 2);
      chk("period2", int'(period_o), 50);
      rand_i = 8'd240; seen = '0; run(50);
      chk("e3_unlocked", int'(seen), 4);
      rand_i = 8'd0;
      run_to(5400);
      chk("level9", int'(level_o), 9);
      chk("period_clamp", int'(period_o), 15);
      run_to(9000);
      chk("level15", int'(level_o), 15);
      run_to(9600);
      chk("level_sat", int'(level_o), 15);
      chk("period_sat", int'(period_o), 15);
      free_i = 3'b000; run(16);
`else
      run_to(700);
      chk("level_tied", int'(level_o), 0);
      chk("period_const", int'(period_o), 60);
      rand_i = 8'd240; seen = '0; run(60);
      chk("e3_always", int'(seen), 4);
      rand_i = 8'd0;
      free_i = 3'b000; run(61);
`endif
      chk("hold_before_rst", int'(spawn_o), 0);
      rst = 1'b1;
      #1;
      chk("async_rst_spawn", int'(spawn_o), 0);
      chk("async_rst_level", int'(level_o), 0);
      chk("async_rst_period", int'(period_o), 60);
      @(negedge clk_vga);
      rst = 1'b0; free_i = 3'b111;
      step();
      seen = '0; run(59); chk("post_rst_early", int'(seen), 0);
      run(1); chk("post_rst_spawn", int'(spawn_o), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
